trace_buffer: RTL and testbench

TRACE_BUFFER -- requirements
Module: trace_buffer

---
 rtl/trace_pkg.sv | 31 +++
 rtl/trace_ram.sv | 58 +++++
 rtl/trace_buffer.sv | 245 ++++++++++++++++++++++++
 tb/tb_trace_buffer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trace_pkg
//  Description : Shared types for the retirement trace buffer: the stored
//                record layout, the capture FSM states and the record width.
//  Revision    : 1.0  initial release
// ============================================================================
package trace_pkg;

    // One captured retirement record; tstamp holds the cycle-counter value
    typedef struct packed {
        logic [31:0] tstamp;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rdv;
        logic [4:0]  rd;
        logic [31:0] rd_data;
    } trace_rec_t;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        CAPTURE  = 2'd2,
        FROZEN   = 2'd3
    } trace_state_e;

    localparam int TRACE_REC_W = $bits(trace_rec_t);

endpackage
`default_nettype wire

// File: rtl/trace_ram.sv
`default_nettype none
// ============================================================================
//  Module      : trace_ram
//  Description : DEPTH x TRACE_REC_W record storage, two write ports, one
//                registered read port. Same-edge writes to the read address
//                are forwarded so the read register always holds the newest
//                contents of the addressed slot.
//  Revision    : 1.0  initial release
// ============================================================================
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we0,
    input  logic [AW-1:0]          wa0,
    input  logic [TRACE_REC_W-1:0] wd0,
    input  logic                   we1,
    input  logic [AW-1:0]          wa1,
    input  logic [TRACE_REC_W-1:0] wd1,
    input  logic                   re,
    input  logic [AW-1:0]          ra,
    output logic [TRACE_REC_W-1:0] rd
);

    logic [TRACE_REC_W-1:0] r_mem [DEPTH];
    logic [TRACE_REC_W-1:0] r_rd;
    logic [TRACE_REC_W-1:0] w_fwd;

    // Storage writes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we0) r_mem[wa0] <= wd0;
        if (we1) r_mem[wa1] <= wd1;
    end

    // Write-through: a slot written this edge is read with its new value
    always_comb begin
        w_fwd = r_mem[ra];
        if (we0 && (wa0 == ra)) w_fwd = wd0;
        if (we1 && (wa1 == ra)) w_fwd = wd1;
    end

    // Registered read, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd <= '0;
        end else if (re) begin
            r_rd <= w_fwd;
        end
    end

    assign rd = r_rd;

endmodule
`default_nettype wire

// File: rtl/trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : trace_buffer
//  Description : Retirement trace buffer. Captures up to NRET retired
//                instructions per cycle into a circular buffer, with arm /
//                trigger / stop control, stop-on-full or wrap-around mode and
//                lost-record accounting. Oldest record is presented on a
//                valid/ready output.
//                Optional macro TRACE_DISPLAY_EN prints each popped record.
//  Revision    : 1.0  initial release
// ============================================================================
module trace_buffer
    import trace_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NRET-1:0]        ret_valid,
    input  logic [NRET*32-1:0]     ret_pc,
    input  logic [NRET*32-1:0]     ret_inst,
    input  logic [NRET-1:0]        ret_rdv,
    input  logic [NRET*5-1:0]      ret_rd,
    input  logic [NRET*32-1:0]     ret_rd_data,
    input  logic                   arm,
    input  logic                   stop,
    input  logic                   wrap_mode,
    input  logic                   trig_en,
    input  logic [31:0]            trig_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output trace_rec_t             out_rec,
    output logic [1:0]             state,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [15:0]            dropped
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW:0] c_DEPTH = (c_CW+1)'(DEPTH);

    trace_state_e           r_state;
    trace_state_e           w_state_next;
    logic [31:0]            r_time;
    logic [c_AW-1:0]        r_rd_ptr;
    logic [c_AW-1:0]        r_wr_ptr;
    logic [c_AW-1:0]        w_rd_ptr_next;
    logic [c_AW-1:0]        w_wr_ptr_next;
    logic [c_CW-1:0]        r_count;
    logic [c_CW-1:0]        w_count_next;
    logic                   r_overflow;
    logic [15:0]            r_dropped;
    logic                   w_pop;
    logic                   w_hit_seen;
    logic [NRET-1:0]        w_lane_en;
    logic [NRET-1:0]        w_cand;
    trace_rec_t             w_rec [NRET];
    trace_rec_t             w_slot [2];
    logic [1:0]             w_npush;
    logic [1:0]             w_nacc;
    logic [1:0]             w_nover;
    logic [1:0]             w_nlost;
    logic [c_CW:0]          w_space;
    logic [c_CW:0]          w_npush_x;
    logic [16:0]            w_drop_sum;
    logic [TRACE_REC_W-1:0] w_ram_rd;
    logic [c_AW-1:0]        w_wa1;

    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready;

    // Per-lane record formatting; writeback-only lanes carry pc/inst of zero
    for (genvar gi = 0; gi < NRET; gi++) begin : g_lane
        assign w_cand[gi] = w_lane_en[gi] && (ret_valid[gi] || ret_rdv[gi]);
        assign w_rec[gi]  = '{
            tstamp:  r_time,
            valid:   ret_valid[gi],
            pc:      ret_valid[gi] ? ret_pc[gi*32 +: 32]   : 32'h0,
            inst:    ret_valid[gi] ? ret_inst[gi*32 +: 32] : 32'h0,
            rdv:     ret_rdv[gi],
            rd:      ret_rd[gi*5 +: 5],
            rd_data: ret_rd_data[gi*32 +: 32]
        };
    end

    // Lane capture enables: a trigger hit enables its own lane and all younger lanes
    always_comb begin
        w_lane_en  = '0;
        w_hit_seen = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            w_hit_seen = w_hit_seen || (ret_valid[i] && (ret_pc[i*32 +: 32] == trig_pc));
            if (!arm && !stop) begin
                if (r_state == CAPTURE) begin
                    w_lane_en[i] = 1'b1;
                end else if (r_state == ARMED) begin
                    w_lane_en[i] = !trig_en || w_hit_seen;
                end
            end
        end
    end

    // Compact candidates into write slots in lane order
    always_comb begin
        w_npush   = '0;
        w_slot[0] = '0;
        w_slot[1] = '0;
        for (int i = 0; i < NRET; i++) begin
            if (w_cand[i]) begin
                w_slot[w_npush[0]] = w_rec[i];
                w_npush            = w_npush + 2'd1;
            end
        end
    end

    // Occupancy: a pop frees its slot first, then excess pushes are dropped or overwrite
    always_comb begin
        w_npush_x = (c_CW+1)'(w_npush);
        w_space   = c_DEPTH - (c_CW+1)'(r_count) + (c_CW+1)'(w_pop);
        w_nacc    = w_npush;
        w_nover   = '0;
        w_nlost   = '0;
        if (w_npush_x > w_space) begin
            if (wrap_mode) begin
                w_nover = w_npush - w_space[1:0];
                w_nlost = w_nover;
            end else begin
                w_nacc  = w_space[1:0];
                w_nlost = w_npush - w_space[1:0];
            end
        end
        w_count_next  = r_count + c_CW'(w_nacc) - c_CW'(w_nover) - c_CW'(w_pop);
        w_wr_ptr_next = r_wr_ptr + c_AW'(w_nacc);
        w_rd_ptr_next = r_rd_ptr + c_AW'(w_nover) + c_AW'(w_pop);
        w_drop_sum    = {1'b0, r_dropped} + 17'(w_nlost);
        if (arm) begin
            w_count_next  = '0;
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
        end
    end

    // Next-state logic; arm overrides everything, stop-on-full freezes one cycle after filling
    always_comb begin
        w_state_next = r_state;
        if (arm) begin
            w_state_next = ARMED;
        end else begin
            case (r_state)
                ARMED: begin
                    if (stop) begin
                        w_state_next = FROZEN;
                    end else if (!trig_en || w_hit_seen) begin
                        w_state_next = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (stop || (!wrap_mode && (r_count == c_DEPTH[c_CW-1:0]))) begin
                        w_state_next = FROZEN;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= DISARMED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pointers, occupancy, cycle counter and loss accounting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_time     <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else begin
            r_time   <= r_time + 32'd1;
            r_rd_ptr <= w_rd_ptr_next;
            r_wr_ptr <= w_wr_ptr_next;
            r_count  <= w_count_next;
            if (arm) begin
                r_overflow <= 1'b0;
                r_dropped  <= '0;
            end else begin
                if (w_nlost != '0) r_overflow <= 1'b1;
                r_dropped <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            end
        end
    end

    assign w_wa1 = r_wr_ptr + c_AW'(1);

    trace_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk (clk),
        .rst (reset),
        .we0 (w_nacc != 2'd0),
        .wa0 (r_wr_ptr),
        .wd0 (w_slot[0]),
        .we1 (w_nacc == 2'd2),
        .wa1 (w_wa1),
        .wd1 (w_slot[1]),
        .re  (w_count_next != '0),
        .ra  (w_rd_ptr_next),
        .rd  (w_ram_rd)
    );

    assign out_rec  = trace_rec_t'(w_ram_rd);
    assign state    = r_state;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign dropped  = r_dropped;

`ifdef TRACE_DISPLAY_EN
    // Print each record as it leaves the buffer
    always_ff @(posedge clk) begin
        if (!reset && !arm && w_pop) begin
            if (out_rec.valid) begin
                $write("0x%08x (0x%08x)  ", out_rec.pc, out_rec.inst);
            end else begin
                $write("%50s/ ", "");
            end
            if (out_rec.rdv) begin
                $write("x%2d <= 0x%08x", out_rec.rd, out_rec.rd_data);
            end
            $write("\n");
        end
    end
`else
    // Display path not built: block is purely synthesizable
`endif

endmodule
`default_nettype wire

// File: tb/tb_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trace_buffer
//  Description : Self-checking bench for trace_buffer (NRET=2, DEPTH=4).
//                Queue-based reference model plus directed scenarios and a
//                randomized control/retire phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trace_buffer;
    import trace_pkg::*;

    localparam int NRET  = 2;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NRET-1:0]        ret_valid;
    logic [NRET*32-1:0]     ret_pc;
    logic [NRET*32-1:0]     ret_inst;
    logic [NRET-1:0]        ret_rdv;
    logic [NRET*5-1:0]      ret_rd;
    logic [NRET*32-1:0]     ret_rd_data;
    logic                   arm;
    logic                   stop;
    logic                   wrap_mode;
    logic                   trig_en;
    logic [31:0]            trig_pc;
    logic                   out_valid;
    logic                   out_ready;
    trace_rec_t             out_rec;
    logic [1:0]             state;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic [15:0]            dropped;

    always #5 clk = ~clk;

    trace_buffer #(
        .NRET  (NRET),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ret_valid   (ret_valid),
        .ret_pc      (ret_pc),
        .ret_inst    (ret_inst),
        .ret_rdv     (ret_rdv),
        .ret_rd      (ret_rd),
        .ret_rd_data (ret_rd_data),
        .arm         (arm),
        .stop        (stop),
        .wrap_mode   (wrap_mode),
        .trig_en     (trig_en),
        .trig_pc     (trig_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rec     (out_rec),
        .state       (state),
        .count       (count),
        .overflow    (overflow),
        .dropped     (dropped)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    trace_rec_t  m_q[$];
    int          m_state;
    logic [31:0] m_time;
    bit          m_ovf;
    int          m_drop;

    // Advance the model across one clock edge using the inputs currently driven
    task automatic model_step();
        trace_rec_t r;
        int         first;
        int         nxt;
        int         lost;
        bit         pop;
        if (reset) begin
            m_q.delete();
            m_state = 0;
            m_time  = 0;
            m_ovf   = 0;
            m_drop  = 0;
            return;
        end
        pop = (m_q.size() != 0) && out_ready;
        if (arm) begin
            m_q.delete();
            m_ovf   = 0;
            m_drop  = 0;
            m_state = 1;
            m_time  = m_time + 1;
            return;
        end
        first = NRET;
        if (!stop && m_state == 2) first = 0;
        if (!stop && m_state == 1) begin
            if (!trig_en) first = 0;
            else begin
                for (int i = NRET - 1; i >= 0; i--)
                    if (ret_valid[i] && ret_pc[i*32 +: 32] == trig_pc) first = i;
            end
        end
        nxt = m_state;
        if (stop && (m_state == 1 || m_state == 2)) nxt = 3;
        else if (m_state == 1 && first < NRET) nxt = 2;
        else if (m_state == 2 && !wrap_mode && m_q.size() == DEPTH) nxt = 3;
        if (pop) void'(m_q.pop_front());
        lost = 0;
        for (int i = first; i < NRET; i++) begin
            if (ret_valid[i] || ret_rdv[i]) begin
                r.tstamp  = m_time;
                r.valid   = ret_valid[i];
                r.pc      = ret_valid[i] ? ret_pc[i*32 +: 32] : 32'h0;
                r.inst    = ret_valid[i] ? ret_inst[i*32 +: 32] : 32'h0;
                r.rdv     = ret_rdv[i];
                r.rd      = ret_rd[i*5 +: 5];
                r.rd_data = ret_rd_data[i*32 +: 32];
                if (m_q.size() < DEPTH) m_q.push_back(r);
                else if (wrap_mode) begin
                    void'(m_q.pop_front());
                    m_q.push_back(r);
                    lost++;
                end else lost++;
            end
        end
        if (lost > 0) m_ovf = 1;
        m_drop  = (m_drop + lost > 65535) ? 65535 : m_drop + lost;
        m_state = nxt;
        m_time  = m_time + 1;
    endtask

    task automatic compare_all();
        chk("state", state, m_state);
        chk("count", count, m_q.size());
        chk("out_valid", out_valid, m_q.size() != 0);
        chk("overflow", overflow, m_ovf);
        chk("dropped", dropped, m_drop);
        if (m_q.size() != 0) chk("out_rec", out_rec, m_q[0]);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        ret_valid   = '0;
        ret_rdv     = '0;
        ret_pc      = '0;
        ret_inst    = '0;
        ret_rd      = '0;
        ret_rd_data = '0;
        arm         = 1'b0;
        stop        = 1'b0;
        out_ready   = 1'b0;
    endtask

    task automatic set_lane(input int ln, input logic v, input logic rdv, input logic [31:0] pc);
        ret_valid[ln]             = v;
        ret_rdv[ln]               = rdv;
        ret_pc[ln*32 +: 32]       = pc;
        ret_inst[ln*32 +: 32]     = $urandom;
        ret_rd[ln*5 +: 5]         = 5'($urandom);
        ret_rd_data[ln*32 +: 32]  = $urandom;
    endtask

    task automatic do_arm(input logic wm, input logic ten, input logic [31:0] tpc);
        idle();
        wrap_mode = wm;
        trig_en   = ten;
        trig_pc   = tpc;
        arm       = 1'b1;
        tick();
        arm       = 1'b0;
    endtask

    function automatic logic [31:0] rpc(input int k);
        return 32'h1000 + 32'(4 * k);
    endfunction

    task automatic push_pair(input int k);
        idle();
        set_lane(0, 1'b1, 1'b0, rpc(k));
        set_lane(1, 1'b1, 1'b1, rpc(k + 1));
        tick();
        idle();
    endtask

    logic [31:0] t0;

    initial begin
        idle();
        wrap_mode = 1'b0;
        trig_en   = 1'b0;
        trig_pc   = '0;
        reset     = 1'b1;
        tick();
        tick();
        chk("rst_state", state, 2'd0);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_dropped", dropped, 16'h0);
        chk("rst_out_rec", out_rec, '0);
        reset = 1'b0;
        tick();

        // Immediate capture of three lane-0 records, popped in order
        do_arm(1'b0, 1'b0, 32'h0);
        t0 = m_time;
        for (int k = 0; k < 3; k++) begin
            idle();
            set_lane(0, 1'b1, 1'b0, 32'h100 + 32'(4 * k));
            tick();
        end
        idle();
        tick();
        chk("seq_count", count, 3);
        for (int k = 0; k < 3; k++) begin
            chk("seq_pc", out_rec.pc, 32'h100 + 32'(4 * k));
            chk("seq_time", out_rec.tstamp, t0 + 32'(k));
            out_ready = 1'b1;
            tick();
        end
        chk("seq_empty", out_valid, 1'b0);

        // Trigger on the younger lane: older lane excluded
        do_arm(1'b0, 1'b1, 32'h200);
        idle();
        tick();
        chk("trig_wait", state, 2'd1);
        set_lane(0, 1'b1, 1'b0, 32'h1FC);
        set_lane(1, 1'b1, 1'b0, 32'h200);
        tick();
        idle();
        chk("trig_state", state, 2'd2);
        chk("trig_count", count, 1);
        chk("trig_pc", out_rec.pc, 32'h200);

        // Stop-on-full: six records, two lost, frozen
        do_arm(1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 5; k += 2) push_pair(k);
        tick();
        chk("full_count", count, 4);
        chk("full_dropped", dropped, 16'd2);
        chk("full_overflow", overflow, 1'b1);
        chk("full_state", state, 2'd3);
        chk("full_first", out_rec.pc, rpc(1));

        // Wrap mode: six records, oldest two overwritten
        do_arm(1'b1, 1'b0, 32'h0);
        for (int k = 1; k <= 5; k += 2) push_pair(k);
        chk("wrap_count", count, 4);
        chk("wrap_dropped", dropped, 16'd2);
        chk("wrap_state", state, 2'd2);
        for (int k = 3; k <= 6; k++) begin
            chk("wrap_pop", out_rec.pc, rpc(k));
            idle();
            out_ready = 1'b1;
            tick();
        end

        // Full buffer, two pushes and one pop in the same cycle
        do_arm(1'b1, 1'b0, 32'h0);
        push_pair(1);
        push_pair(3);
        chk("fp_pop_rec", out_rec.pc, rpc(1));
        set_lane(0, 1'b1, 1'b0, rpc(5));
        set_lane(1, 1'b1, 1'b0, rpc(6));
        out_ready = 1'b1;
        tick();
        idle();
        chk("fp_count", count, 4);
        chk("fp_dropped", dropped, 16'd1);
        chk("fp_next", out_rec.pc, rpc(3));

        // Arm during capture clears occupancy and loss accounting
        do_arm(1'b1, 1'b0, 32'h0);
        push_pair(1);
        push_pair(3);
        push_pair(5);
        push_pair(7);
        set_lane(0, 1'b1, 1'b0, rpc(9));
        tick();
        idle();
        out_ready = 1'b1;
        tick();
        idle();
        chk("rearm_pre_count", count, 3);
        chk("rearm_pre_drop", dropped, 16'd5);
        arm = 1'b1;
        set_lane(0, 1'b1, 1'b0, rpc(10));
        out_ready = 1'b1;
        tick();
        idle();
        chk("rearm_count", count, 0);
        chk("rearm_dropped", dropped, 16'd0);
        chk("rearm_overflow", overflow, 1'b0);
        chk("rearm_state", state, 2'd1);

        // Randomized control, retire and consumer traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            idle();
            r = $urandom_range(0, 99);
            if (r < 3) begin
                arm     = 1'b1;
                trig_en = 1'($urandom_range(0, 1));
                trig_pc = 32'h200 + 32'(4 * $urandom_range(0, 7));
            end else if (r < 5) begin
                stop = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) wrap_mode = ~wrap_mode;
            for (int ln = 0; ln < NRET; ln++)
                set_lane(ln, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                         32'h200 + 32'(4 * $urandom_range(0, 7)));
            out_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end

        // Dropped counter saturation under sustained wrap-around overflow
        do_arm(1'b1, 1'b0, 32'h0);
        set_lane(0, 1'b1, 1'b0, 32'h300);
        set_lane(1, 1'b1, 1'b0, 32'h304);
        for (int c = 0; c < 32800; c++) tick();
        idle();
        tick();
        chk("sat_dropped", dropped, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
